// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: word-aligned fetch address generation, a
// one-outstanding request/ack handshake to instruction memory, a 2-entry
// {pc, word} buffer toward the decoder, and redirect-driven flush/restart.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StDiscard = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_fetch_pc;
  logic [31:0] w_fetch_pc_next;
  logic [31:0] r_req_addr;
  logic [31:0] w_req_addr_next;

  // Two-entry buffer, head selected by r_rd_ptr
  logic [31:0] r_fifo_pc   [2];
  logic [31:0] r_fifo_word [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic        w_pop;
  logic        w_push;
  logic [2:0]  w_occ_next;
  logic        w_room;
  logic [31:0] w_req_addr_inc;
  logic [31:0] w_target_aligned;

  assign w_pop            = instr_valid & instr_ready;
  assign w_push           = (r_state == StWait) & imem_ack & ~redirect;
  // Occupancy after this edge's push/pop; a new request may only be in flight
  // when at most one entry will be held, which rules out overflow.
  assign w_occ_next       = {1'b0, r_count} + {2'b00, w_push} - {2'b00, w_pop};
  assign w_room           = (w_occ_next <= 3'd1);
  assign w_req_addr_inc   = r_req_addr + 32'd4;
  assign w_target_aligned = {redirect_target[31:2], 2'b00};

  // Next-state, next fetch PC and next request address
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_req_addr_next = r_req_addr;
    if (redirect) begin
      w_fetch_pc_next = w_target_aligned;
      case (r_state)
        StIdle:    w_state_next = StIdle;
        // The in-flight request cannot be withdrawn; wait out its ack
        StWait:    w_state_next = imem_ack ? StIdle : StDiscard;
        StDiscard: w_state_next = imem_ack ? StIdle : StDiscard;
        default:   w_state_next = StIdle;
      endcase
    end else begin
      case (r_state)
        StIdle: begin
          if (w_room) begin
            w_req_addr_next = r_fetch_pc;
            w_state_next    = StWait;
          end
        end
        StWait: begin
          if (imem_ack) begin
            w_fetch_pc_next = w_req_addr_inc;
            if (w_room) begin
              // Back-to-back fetch of the next sequential word
              w_req_addr_next = w_req_addr_inc;
            end else begin
              w_state_next = StIdle;
            end
          end
        end
        StDiscard: begin
          if (imem_ack) begin
            w_state_next = StIdle;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Control state, fetch PC, request address and buffer bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= 32'h0;
      r_count    <= 2'd0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_req_addr <= w_req_addr_next;
      if (redirect) begin
        // A same-cycle pop is still consumed; the flush discards the rest
        r_count  <= 2'd0;
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
      end else begin
        r_count <= w_occ_next[1:0];
        if (w_push) begin
          r_wr_ptr <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
      end
    end
  end

  // Buffer storage; contents are only visible while r_count is non-zero
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_req_addr;
      r_fifo_word[r_wr_ptr] <= imem_rdata;
    end
  end

  // Memory request and decoder-facing outputs
  always_comb begin
    imem_req    = (r_state != StIdle);
    imem_addr   = r_req_addr;
    instr_valid = (r_count != 2'd0);
    instr       = 32'h0;
    instr_pc    = 32'h0;
    if (instr_valid) begin
      instr    = r_fifo_word[r_rd_ptr];
      instr_pc = r_fifo_pc[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Reference model: delivered-but-unconsumed instructions as a queue, plus
  // the one outstanding memory request and whether its data is still wanted.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_next  = 32'h0;
  logic [31:0] m_addr  = 32'h0;
  bit          m_busy  = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_known = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE081_0002;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_step();
    bit   pop;
    bit   ack_e;
    ent_t e;
    if (reset) begin
      m_q.delete();
      m_next  = RESET_PC;
      m_addr  = 32'h0;
      m_busy  = 1'b0;
      m_stale = 1'b0;
      m_known = 1'b1;
      return;
    end
    if (!m_known) return;
    pop   = (m_q.size() > 0) && instr_ready;
    ack_e = m_busy && imem_ack;
    if (redirect) begin
      m_q.delete();
      m_next = redirect_target & ~32'h3;
      if (ack_e) begin
        m_busy  = 1'b0;
        m_stale = 1'b0;
      end else if (m_busy) begin
        m_stale = 1'b1;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (ack_e) begin
        if (m_stale) begin
          m_busy  = 1'b0;
          m_stale = 1'b0;
        end else begin
          e.pc   = m_addr;
          e.word = imem_rdata;
          m_q.push_back(e);
          m_next = m_addr + 32'd4;
          if (m_q.size() <= 1) m_addr = m_addr + 32'd4;
          else m_busy = 1'b0;
        end
      end else if (!m_busy && m_q.size() <= 1) begin
        m_addr = m_next;
        m_busy = 1'b1;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    exp_instr = (m_q.size() > 0) ? m_q[0].word : 32'h0;
    exp_pc    = (m_q.size() > 0) ? m_q[0].pc   : 32'h0;
    check_eq("imem_req",    {31'h0, imem_req},    {31'h0, m_busy});
    check_eq("imem_addr",   imem_addr,            m_addr);
    check_eq("instr_valid", {31'h0, instr_valid}, {31'h0, (m_q.size() > 0)});
    check_eq("instr",       instr,                exp_instr);
    check_eq("instr_pc",    instr_pc,             exp_pc);
  endtask

  // One clock: check state left by the previous edge, drive, clock, advance model
  task automatic cycle(input bit rst, input bit rd, input logic [31:0] tgt,
                       input bit ack, input bit rdy);
    @(negedge clk);
    if (m_known) compare_outputs();
    reset           = rst;
    redirect        = rd;
    redirect_target = tgt;
    imem_ack        = ack;
    instr_ready     = rdy;
    imem_rdata      = mem_word(m_addr);
    @(posedge clk);
    model_step();
  endtask

  initial begin
    logic [31:0] tgt;
    bit          rst;
    bit          rd;

    // Reset
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    // Zero-wait streaming
    repeat (20) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    // Backpressure fills the buffer, then drains without gaps
    repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect while waiting on 0x10, ack delayed 3 cycles
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (m_busy && m_addr == 32'h10) break;
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    end
    check_eq("reach_0x10", m_addr, 32'h10);
    cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect coinciding with an ack and a pop
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Address wrap at the top of memory
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Reset during DISCARD, then a stray ack
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 99) < 6);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      cycle(rst, rd, tgt, ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 65));
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
